// File: rtl/wsn_pkg.sv
// Shared constants and types for the neighbor table kept in shared memory.
package wsn_pkg;

  localparam int unsigned WORD_WIDTH  = 16;
  localparam logic [15:0] TBL_BASE    = 16'h0400;
  localparam int unsigned OFS_ID      = 0;
  localparam int unsigned OFS_BATT    = 2;
  localparam int unsigned OFS_VAL     = 4;
  localparam int unsigned OFS_CLU     = 6;
  localparam int unsigned ENTRY_BYTES = 8;
  localparam int unsigned MAX_NBR     = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

  // One neighbor table entry, fields in memory order
  typedef struct packed {
    word_t id;
    word_t batt;
    word_t val;
    word_t clu;
  } nbr_entry_t;

  // Byte address of field ofs of entry k; entry 0 follows the count word
  function automatic word_t entry_addr(input word_t base, input int unsigned k,
                                       input int unsigned ofs);
    return word_t'(32'(base) + 32'(2 + k * ENTRY_BYTES + ofs));
  endfunction

endpackage

// File: rtl/best_hop_select_if.sv
// Request/result and memory-port signals of best_hop_select.
interface best_hop_select_if #(
  parameter int unsigned WIDTH = wsn_pkg::WORD_WIDTH
);
  import wsn_pkg::*;

  logic             start;
  logic [WIDTH-1:0] clusterID;
  logic [WIDTH-1:0] minBattery;
  logic [WIDTH-1:0] address;
  logic             wr_en;
  logic [WIDTH-1:0] mem_data_out;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] bestID;
  logic [WIDTH-1:0] bestValue;

  // Requester and memory side
  modport master (
    output start, clusterID, minBattery, mem_data_out,
    input  address, wr_en, busy, done, found, bestID, bestValue
  );

  // Scanner side
  modport slave (
    input  start, clusterID, minBattery, mem_data_out,
    output address, wr_en, busy, done, found, bestID, bestValue
  );

endinterface

// File: rtl/best_hop_select.sv
// Scans the neighbor table and reports the cheapest eligible next hop.
// Read-only on the shared memory port; one word per cycle, 1-cycle read latency.
module best_hop_select
  import wsn_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH = wsn_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] TBL_BASE   = wsn_pkg::TBL_BASE,
  parameter int unsigned           MAX_NBR    = wsn_pkg::MAX_NBR
) (
  input  logic             clock,
  input  logic             nrst,
  best_hop_select_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(MAX_NBR + 1);
  localparam int unsigned WCNT_W = $clog2(4 * MAX_NBR + 1);
  localparam logic [WORD_WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WORD_WIDTH-1:0] WORD_STEP = WORD_WIDTH'(2);

  typedef enum logic [1:0] {ST_IDLE, ST_RD_CNT, ST_SCAN, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      n_q, n_d;
  logic [WCNT_W-1:0]     j_q, j_d;
  logic [WORD_WIDTH-1:0] req_clu_q, req_clu_d;
  logic [WORD_WIDTH-1:0] req_batt_q, req_batt_d;
  logic [WORD_WIDTH-1:0] cur_id_q, cur_id_d;
  logic [WORD_WIDTH-1:0] cur_batt_q, cur_batt_d;
  logic [WORD_WIDTH-1:0] cur_val_q, cur_val_d;
  logic [WORD_WIDTH-1:0] best_id_q, best_id_d;
  logic [WORD_WIDTH-1:0] best_val_q, best_val_d;
  logic                  found_q, found_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  res_found_q, res_found_d;
  logic [WORD_WIDTH-1:0] res_id_q, res_id_d;
  logic [WORD_WIDTH-1:0] res_val_q, res_val_d;

  logic [WCNT_W-1:0]     n4_c;
  logic [2:0]            cap_ofs_c;
  logic [CNT_W-1:0]      clamp_c;
  logic                  elig_c;
  logic                  win_c;

  // Scan length in words, byte offset of the word arriving now, clamped count
  assign n4_c      = WCNT_W'({n_q, 2'b00});
  assign cap_ofs_c = {2'(j_q - WCNT_W'(1)), 1'b0};
  assign clamp_c   = (bus.mem_data_out > WORD_WIDTH'(MAX_NBR)) ? CNT_W'(MAX_NBR)
                                                                : CNT_W'(bus.mem_data_out);

  // Entry evaluation happens as its clusterID word arrives; ties keep the earlier entry
  assign elig_c = (bus.mem_data_out == req_clu_q) && (cur_batt_q >= req_batt_q);
  assign win_c  = elig_c && (!found_q || (cur_val_q < best_val_q));

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    n_d         = n_q;
    j_d         = j_q;
    req_clu_d   = req_clu_q;
    req_batt_d  = req_batt_q;
    cur_id_d    = cur_id_q;
    cur_batt_d  = cur_batt_q;
    cur_val_d   = cur_val_q;
    best_id_d   = best_id_q;
    best_val_d  = best_val_q;
    found_d     = found_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_found_d = res_found_q;
    res_id_d    = res_id_q;
    res_val_d   = res_val_q;

    case (state_q)
      ST_IDLE: begin
        addr_d = TBL_BASE;
        if (bus.start) begin
          state_d    = ST_RD_CNT;
          req_clu_d  = bus.clusterID;
          req_batt_d = bus.minBattery;
          best_id_d  = ALL_ONES;
          best_val_d = ALL_ONES;
          found_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_RD_CNT: begin
        n_d = clamp_c;
        j_d = '0;
        if (clamp_c == '0) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          res_found_d = found_q;
          res_id_d    = best_id_q;
          res_val_d   = best_val_q;
        end else begin
          state_d = ST_SCAN;
          addr_d  = TBL_BASE + WORD_STEP;
        end
      end

      ST_SCAN: begin
        j_d = j_q + WCNT_W'(1);
        if ((j_q + WCNT_W'(1)) < n4_c) begin
          addr_d = addr_q + WORD_STEP;
        end
        if (j_q != '0) begin
          case (cap_ofs_c)
            3'(OFS_ID):   cur_id_d   = bus.mem_data_out;
            3'(OFS_BATT): cur_batt_d = bus.mem_data_out;
            3'(OFS_VAL):  cur_val_d  = bus.mem_data_out;
            default: begin
              if (win_c) begin
                best_id_d  = cur_id_q;
                best_val_d = cur_val_q;
                found_d    = 1'b1;
              end
            end
          endcase
        end
        if (j_q == n4_c) begin
          state_d     = ST_DONE;
          addr_d      = TBL_BASE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          res_found_d = found_d;
          res_id_d    = best_id_d;
          res_val_d   = best_val_d;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = TBL_BASE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      addr_q      <= TBL_BASE;
      n_q         <= '0;
      j_q         <= '0;
      req_clu_q   <= '0;
      req_batt_q  <= '0;
      cur_id_q    <= '0;
      cur_batt_q  <= '0;
      cur_val_q   <= '0;
      best_id_q   <= ALL_ONES;
      best_val_q  <= ALL_ONES;
      found_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_found_q <= 1'b0;
      res_id_q    <= ALL_ONES;
      res_val_q   <= ALL_ONES;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      j_q         <= j_d;
      req_clu_q   <= req_clu_d;
      req_batt_q  <= req_batt_d;
      cur_id_q    <= cur_id_d;
      cur_batt_q  <= cur_batt_d;
      cur_val_q   <= cur_val_d;
      best_id_q   <= best_id_d;
      best_val_q  <= best_val_d;
      found_q     <= found_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_found_q <= res_found_d;
      res_id_q    <= res_id_d;
      res_val_q   <= res_val_d;
    end
  end

  assign bus.address   = addr_q;
  assign bus.wr_en     = 1'b0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = res_found_q;
  assign bus.bestID    = res_id_q;
  assign bus.bestValue = res_val_q;

endmodule

// File: tb/tb_best_hop_select.sv
// Bench for best_hop_select: memory model, reference model, per-cycle compare.
module tb_best_hop_select;
  import wsn_pkg::*;

  logic clock = 1'b0;
  logic nrst  = 1'b0;

  best_hop_select_if bus ();

  best_hop_select #(
    .WORD_WIDTH(WORD_WIDTH),
    .TBL_BASE  (TBL_BASE),
    .MAX_NBR   (MAX_NBR)
  ) dut (
    .clock(clock),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Word-addressed memory answering one cycle after the address
  logic [15:0] mem [0:32767];
  always @(posedge clock) bus.mem_data_out <= mem[bus.address[15:1]];

  nbr_entry_t tbl [0:19];

  // Expectations written by the stimulus side
  int          scan_req = 0;
  int          exp_n    = 0;
  int          done_cyc = 2;
  logic        exp_found = 1'b0;
  logic [15:0] exp_id    = 16'hFFFF;
  logic [15:0] exp_val   = 16'hFFFF;

  // State owned by the compare process
  int          scan_ack   = 0;
  bit          running    = 1'b0;
  int          cyc        = 0;
  int          done_seen  = 0;
  logic [15:0] last_addr  = 16'h0;
  logic        prev_found = 1'b0;
  logic [15:0] prev_id    = 16'hFFFF;
  logic [15:0] prev_val   = 16'hFFFF;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic put(input logic [15:0] a, input logic [15:0] d);
    mem[a[15:1]] = d;
  endtask

  task automatic set_ent(input int unsigned k, input logic [15:0] id, input logic [15:0] b,
                         input logic [15:0] v, input logic [15:0] c);
    tbl[k] = '{id: id, batt: b, val: v, clu: c};
  endtask

  task automatic load_table(input logic [15:0] cnt);
    put(TBL_BASE, cnt);
    for (int unsigned k = 0; k < 20; k++) begin
      put(entry_addr(TBL_BASE, k, OFS_ID),   tbl[k].id);
      put(entry_addr(TBL_BASE, k, OFS_BATT), tbl[k].batt);
      put(entry_addr(TBL_BASE, k, OFS_VAL),  tbl[k].val);
      put(entry_addr(TBL_BASE, k, OFS_CLU),  tbl[k].clu);
    end
  endtask

  // Reference: minimum cost among eligible entries, then the first entry holding it
  task automatic model(input logic [15:0] cnt, input logic [15:0] clu, input logic [15:0] minb);
    int          n;
    int          best_k;
    bit          any;
    logic [15:0] min_v;
    n      = (cnt > 16'(MAX_NBR)) ? int'(MAX_NBR) : int'(cnt);
    any    = 1'b0;
    min_v  = 16'hFFFF;
    best_k = -1;
    for (int k = 0; k < n; k++) begin
      if (tbl[k].clu == clu && tbl[k].batt >= minb) begin
        any = 1'b1;
        if (tbl[k].val < min_v) min_v = tbl[k].val;
      end
    end
    for (int k = n - 1; k >= 0; k--) begin
      if (tbl[k].clu == clu && tbl[k].batt >= minb && tbl[k].val == min_v) best_k = k;
    end
    exp_n     = n;
    done_cyc  = (n == 0) ? 2 : 3 + 4 * n;
    exp_found = any;
    exp_id    = any ? tbl[best_k].id : 16'hFFFF;
    exp_val   = any ? min_v : 16'hFFFF;
  endtask

  // Address the DUT must present in scan cycle c (1 = RD_CNT)
  function automatic logic [15:0] exp_addr(input int c);
    int w;
    if (c < 2) return TBL_BASE;
    w = c - 2;
    if (w > 4 * exp_n - 1) w = 4 * exp_n - 1;
    return TBL_BASE + 16'(2 + 2 * w);
  endfunction

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge clock) begin
    if (!nrst) begin
      running    = 1'b0;
      scan_ack   = scan_req;
      prev_found = 1'b0;
      prev_id    = 16'hFFFF;
      prev_val   = 16'hFFFF;
    end
    if (scan_req != scan_ack) begin
      if (!running) begin
        running   = 1'b1;
        cyc       = 0;
        done_seen = 0;
      end
      cyc++;
      chk("wr_en", 16'(bus.wr_en), 16'h0);
      if (bus.done && done_seen == 0) done_seen = cyc;
      if (cyc < done_cyc) begin
        chk("address", bus.address, exp_addr(cyc));
        last_addr = bus.address;
        chk("busy", 16'(bus.busy), 16'h1);
        chk("done_early", 16'(bus.done), 16'h0);
        chk("found_held", 16'(bus.found), 16'(prev_found));
        chk("bestID_held", bus.bestID, prev_id);
        chk("bestValue_held", bus.bestValue, prev_val);
      end else begin
        chk("done", 16'(bus.done), 16'h1);
        chk("found", 16'(bus.found), 16'(exp_found));
        chk("bestID", bus.bestID, exp_id);
        chk("bestValue", bus.bestValue, exp_val);
        prev_found = exp_found;
        prev_id    = exp_id;
        prev_val   = exp_val;
        running    = 1'b0;
        scan_ack   = scan_req;
      end
    end else begin
      chk("idle_address", bus.address, TBL_BASE);
      chk("idle_wr_en", 16'(bus.wr_en), 16'h0);
      chk("idle_busy", 16'(bus.busy), 16'h0);
      chk("idle_done", 16'(bus.done), 16'h0);
      chk("idle_found", 16'(bus.found), 16'(prev_found));
      chk("idle_bestID", bus.bestID, prev_id);
      chk("idle_bestValue", bus.bestValue, prev_val);
    end
  end

  task automatic launch(input logic [15:0] clu, input logic [15:0] minb, input bit hold);
    @(negedge clock);
    bus.start      = 1'b1;
    bus.clusterID  = clu;
    bus.minBattery = minb;
    @(posedge clock);
    #1 scan_req++;
    if (!hold) begin
      @(negedge clock);
      bus.start      = 1'b0;
      bus.clusterID  = 16'($urandom);
      bus.minBattery = 16'($urandom);
    end
  endtask

  task automatic wait_done();
    int budget = 400;
    while (scan_req != scan_ack && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    if (budget == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scan_timeout: scan did not complete within 400 cycles (t=%0t)", $time);
    end
    #1;
  endtask

  task automatic run(input logic [15:0] cnt, input logic [15:0] clu, input logic [15:0] minb);
    load_table(cnt);
    model(cnt, clu, minb);
    launch(clu, minb, 1'b0);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.start      = 1'b0;
    bus.clusterID  = 16'h0;
    bus.minBattery = 16'h0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0;
    // Entries past the stored count are cheap and eligible, so over-reading shows up
    for (int unsigned k = 0; k < 20; k++) set_ent(k, 16'd99, 16'd15, 16'd0, 16'd11);

    repeat (3) @(posedge clock);
    #1 nrst = 1'b1;
    @(negedge clock);
    #1;
    chk("rst_address", bus.address, 16'h0400);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    chk("rst_found", 16'(bus.found), 16'h0);
    chk("rst_bestID", bus.bestID, 16'hFFFF);
    chk("rst_bestValue", bus.bestValue, 16'hFFFF);

    // Empty table
    run(16'd0, 16'd11, 16'd0);
    chk("empty_done_cycle", 16'(done_seen), 16'd2);
    chk("empty_found", 16'(bus.found), 16'h0);
    chk("empty_bestID", bus.bestID, 16'hFFFF);

    // Three entries in cluster 11
    set_ent(0, 16'd31, 16'd5, 16'd10, 16'd11);
    set_ent(1, 16'd7,  16'd9, 16'd4,  16'd11);
    set_ent(2, 16'd12, 16'd3, 16'd20, 16'd11);
    run(16'd3, 16'd11, 16'd0);
    chk("three_bestID", bus.bestID, 16'd7);
    chk("three_bestValue", bus.bestValue, 16'd4);
    chk("three_found", 16'(bus.found), 16'h1);
    chk("three_done_cycle", 16'(done_seen), 16'd15);
    run(16'd3, 16'd11, 16'd6);
    chk("minbatt6_bestID", bus.bestID, 16'd7);
    run(16'd3, 16'd11, 16'd10);
    chk("minbatt10_found", 16'(bus.found), 16'h0);
    chk("minbatt10_bestID", bus.bestID, 16'hFFFF);

    // Tie and cluster filter
    set_ent(0, 16'd31, 16'd5, 16'd10, 16'd11);
    set_ent(1, 16'd8,  16'd5, 16'd10, 16'd11);
    set_ent(2, 16'd2,  16'd5, 16'd1,  16'd3);
    run(16'd3, 16'd11, 16'd0);
    chk("tie_bestID", bus.bestID, 16'd31);
    chk("tie_bestValue", bus.bestValue, 16'd10);

    // Stored count above the limit; entry 17 would win if it were read
    for (int unsigned k = 0; k < 20; k++)
      set_ent(k, 16'(100 + k), 16'd8, 16'($urandom_range(5, 60)), 16'd11);
    set_ent(17, 16'd77, 16'd15, 16'd0, 16'd11);
    run(16'd40, 16'd11, 16'd0);
    chk("clamp_last_addr", last_addr, 16'h0480);
    chk("clamp_done_cycle", 16'(done_seen), 16'd67);
    chk("clamp_not_17", 16'(bus.bestID == 16'd77), 16'h0);

    // Start held high: back-to-back scans
    load_table(16'd2);
    model(16'd2, 16'd11, 16'd0);
    launch(16'd11, 16'd0, 1'b1);
    wait_done();
    @(posedge clock);
    #1 scan_req++;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done();
    chk("restart_done_cycle", 16'(done_seen), 16'd11);

    // Reset in the middle of a scan
    load_table(16'd5);
    model(16'd5, 16'd11, 16'd0);
    launch(16'd11, 16'd0, 1'b0);
    repeat (9) @(posedge clock);
    #1 nrst = 1'b0;
    repeat (3) @(posedge clock);
    #1 nrst = 1'b1;
    wait_done();
    chk("abort_no_done", 16'(done_seen), 16'd0);
    chk("abort_bestID", bus.bestID, 16'hFFFF);
    chk("abort_found", 16'(bus.found), 16'h0);

    // Randomized tables and requests
    for (int t = 0; t < 40; t++) begin
      logic [15:0] cnt;
      for (int unsigned k = 0; k < 20; k++)
        set_ent(k, 16'($urandom), 16'($urandom_range(0, 15)),
                ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 50)),
                16'($urandom_range(1, 3)));
      case ($urandom_range(0, 5))
        0:       cnt = 16'hFFFF;
        1:       cnt = 16'd0;
        default: cnt = 16'($urandom_range(1, 20));
      endcase
      run(cnt, 16'($urandom_range(1, 3)), 16'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
